cnn_host_sequencer: RTL

// - Host-side initiator for the accelerator top controller: streams one 50x50x1 int8 image into input RAM via the
//   tb write port, pulses start_flag, waits for end_flag, captures NN_out_female/male, returns a result record.
// - Sits between a byte-stream source (DMA/UART bridge) and the accelerator; it is the only driver of *_wtb and start_flag.

---
 rtl/cnn_host_pkg.sv | 29 ++
 rtl/cnn_run_timer.sv | 38 +++
 rtl/cnn_host_sequencer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/cnn_host_pkg.sv
// Shared types for the CNN host sequencer.
// - state_e  : sequencer FSM states
// - status_e : result status codes reported with each result record
// - male_wins: signed logit comparison used for the class decision
package cnn_host_pkg;

    localparam int unsigned IMG_BYTES_DEF = 2500;

    typedef enum logic [2:0] {
        StLoad,
        StArm,
        StStart,
        StRun,
        StResult,
        StFault
    } state_e;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_TIMEOUT = 2'd1,
        ST_SHORT   = 2'd2
    } status_e;

    // Ties resolve to female.
    function automatic logic male_wins(input logic [7:0] female, input logic [7:0] male);
        return $signed(male) > $signed(female);
    endfunction

endpackage

// File: rtl/cnn_run_timer.sv
// Run-latency counter for the host sequencer.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   i_clear     load the counter with 1 (the START cycle counts as cycle 1)
//   i_enable    increment, saturating at all-ones
//   o_count     current count
//   o_timeout   count has reached TIMEOUT
module cnn_run_timer #(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned TIMEOUT = 2**20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_count,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= CNT_W'(1);
        end else if (i_enable && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count   = r_count;
    assign o_timeout = (r_count >= CNT_LIMIT);

endmodule

// File: rtl/cnn_host_sequencer.sv
// Host-side initiator for the CNN accelerator: loads one image into the input RAM through the
// tb write port, kicks the accelerator, waits for DONE and returns a result record.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   i_s_valid/o_s_ready/i_s_data  image byte stream (raster order), i_s_last end-of-frame marker
//   o_ram_*_wtb                   input RAM write port (address, data, enable, write enable)
//   o_start_flag / i_end_flag     one-cycle run request / accelerator DONE
//   i_nn_out_female/_male         signed logits, valid while i_end_flag
//   o_res_* / i_res_ready         result record, held until accepted
//   o_busy                        sequencer not in LOAD
// All outputs are registered.
module cnn_host_sequencer
    import cnn_host_pkg::*;
#(
    parameter int unsigned IMG_BYTES = IMG_BYTES_DEF,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned TIMEOUT   = 2**20,
    parameter int unsigned CNT_W     = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [7:0]        i_s_data,
    input  logic              i_s_last,
    output logic [ADDR_W-1:0] o_ram_addr_wtb,
    output logic [7:0]        o_ram_data_wtb,
    output logic              o_ram_en_wtb,
    output logic              o_ram_wea_wtb,
    output logic              o_start_flag,
    input  logic              i_end_flag,
    input  logic [7:0]        i_nn_out_female,
    input  logic [7:0]        i_nn_out_male,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [7:0]        o_res_female,
    output logic [7:0]        o_res_male,
    output logic              o_res_class,
    output logic [1:0]        o_res_status,
    output logic [CNT_W-1:0]  o_res_cycles,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

    state_e            r_state, w_state_next;
    logic [ADDR_W-1:0] r_cnt, w_cnt;
    logic              r_s_ready, r_ram_en, w_ram_en, r_start, r_busy;
    logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
    logic [7:0]        r_ram_data, w_ram_data;
    logic              r_res_valid, w_res_valid;
    logic [7:0]        r_res_female, w_res_female, r_res_male, w_res_male;
    logic              r_res_class, w_res_class;
    status_e           r_res_status, w_res_status;
    logic [CNT_W-1:0]  r_res_cycles, w_res_cycles;

    logic              w_handshake, w_tmr_clear, w_tmr_en, w_tmr_timeout;
    logic [CNT_W-1:0]  w_tmr_count;

    cnn_run_timer #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_en),
        .o_count   (w_tmr_count),
        .o_timeout (w_tmr_timeout)
    );

    // s_ready is registered, so a byte is taken only when the registered ready was high.
    assign w_handshake = r_s_ready & i_s_valid;

    always_comb begin
        w_state_next = r_state;
        w_cnt        = r_cnt;
        w_ram_en     = 1'b0;
        w_ram_addr   = r_ram_addr;
        w_ram_data   = r_ram_data;
        w_res_valid  = r_res_valid;
        w_res_female = r_res_female;
        w_res_male   = r_res_male;
        w_res_class  = r_res_class;
        w_res_status = r_res_status;
        w_res_cycles = r_res_cycles;
        w_tmr_clear  = 1'b0;
        w_tmr_en     = 1'b0;

        unique case (r_state)
            StLoad: begin
                if (w_handshake) begin
                    w_ram_en   = 1'b1;
                    w_ram_addr = r_cnt;
                    w_ram_data = i_s_data;
                    if (r_cnt == LAST_ADDR) begin
                        w_cnt        = '0;
                        w_state_next = StArm;
                    end else if (i_s_last) begin
                        // Early end-of-frame: the byte is still written, no run is started.
                        w_cnt        = '0;
                        w_res_valid  = 1'b1;
                        w_res_female = '0;
                        w_res_male   = '0;
                        w_res_class  = 1'b0;
                        w_res_status = ST_SHORT;
                        w_res_cycles = '0;
                        w_state_next = StResult;
                    end else begin
                        w_cnt = r_cnt + 1'b1;
                    end
                end
            end
            StArm: begin
                // A DONE still high from a previous run must clear before a new start.
                if (!i_end_flag) begin
                    w_state_next = StStart;
                end
            end
            StStart: begin
                w_tmr_clear  = 1'b1;
                w_state_next = StRun;
            end
            StRun: begin
                w_tmr_en = 1'b1;
                if (i_end_flag) begin
                    w_res_valid  = 1'b1;
                    w_res_female = i_nn_out_female;
                    w_res_male   = i_nn_out_male;
                    w_res_class  = male_wins(i_nn_out_female, i_nn_out_male);
                    w_res_status = ST_OK;
                    w_res_cycles = w_tmr_count;
                    w_state_next = StResult;
                end else if (w_tmr_timeout) begin
                    w_res_valid  = 1'b1;
                    w_res_female = '0;
                    w_res_male   = '0;
                    w_res_class  = 1'b0;
                    w_res_status = ST_TIMEOUT;
                    w_res_cycles = w_tmr_count;
                    w_state_next = StResult;
                end
            end
            StResult: begin
                if (r_res_valid && i_res_ready) begin
                    w_res_valid  = 1'b0;
                    w_state_next = (r_res_status == ST_TIMEOUT) ? StFault : StLoad;
                end
            end
            StFault: begin
                w_state_next = StFault;
            end
            default: begin
                w_state_next = StLoad;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StLoad;
            r_cnt        <= '0;
            r_s_ready    <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_data   <= '0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_female <= '0;
            r_res_male   <= '0;
            r_res_class  <= 1'b0;
            r_res_status <= ST_OK;
            r_res_cycles <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt;
            r_s_ready    <= (w_state_next == StLoad);
            r_ram_en     <= w_ram_en;
            r_ram_addr   <= w_ram_addr;
            r_ram_data   <= w_ram_data;
            r_start      <= (w_state_next == StStart);
            r_busy       <= (w_state_next != StLoad);
            r_res_valid  <= w_res_valid;
            r_res_female <= w_res_female;
            r_res_male   <= w_res_male;
            r_res_class  <= w_res_class;
            r_res_status <= w_res_status;
            r_res_cycles <= w_res_cycles;
        end
    end

    assign o_s_ready      = r_s_ready;
    assign o_ram_addr_wtb = r_ram_addr;
    assign o_ram_data_wtb = r_ram_data;
    assign o_ram_en_wtb   = r_ram_en;
    assign o_ram_wea_wtb  = r_ram_en;
    assign o_start_flag   = r_start;
    assign o_busy         = r_busy;
    assign o_res_valid    = r_res_valid;
    assign o_res_female   = r_res_female;
    assign o_res_male     = r_res_male;
    assign o_res_class    = r_res_class;
    assign o_res_status   = r_res_status;
    assign o_res_cycles   = r_res_cycles;

endmodule
